// File: rtl/conv_window_loader.sv
// Sliding-window loader: pops FIFO samples and presents KERNEL_SIZE-sample windows per frame.
// Optional stall counter output enabled by defining CONV_WINDOW_LOADER_STALL_CNT_EN.
module conv_window_loader #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 3,
   parameter int FRAME_LEN   = 8
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [DATA_WIDTH-1:0]             fifo_data_i,
   input  logic                              fifo_empty_i,
   output logic                              fifo_ren_o,
   output logic [KERNEL_SIZE*DATA_WIDTH-1:0] window_o,
   output logic                              valid_o,
   input  logic                              ready_i,
   output logic                              last_o
`ifdef CONV_WINDOW_LOADER_STALL_CNT_EN
   ,
   output logic [15:0]                       stall_cnt_o
`endif
);

   localparam int WW       = KERNEL_SIZE * DATA_WIDTH;
   localparam int FCW      = $clog2(KERNEL_SIZE + 1);
   localparam int LAST_WIN = FRAME_LEN - KERNEL_SIZE;
   localparam int WCW      = (LAST_WIN < 1) ? 1 : $clog2(LAST_WIN + 1);

   typedef enum logic [1:0] {FILL, EMIT, WAIT} state_t;

   state_t           state_reg;
   logic [FCW-1:0]   fill_cnt_reg;
   logic [WCW-1:0]   win_cnt_reg;
   logic [WCW-1:0]   win_cnt_next;
   logic [WW-1:0]    window_reg;
   logic [WW-1:0]    window_next;
   logic             valid_reg;
   logic             last_reg;
   logic             handshake;
   logic             pop;

   assign handshake    = valid_reg & ready_i;
   assign win_cnt_next = win_cnt_reg + 1'b1;
   // newest sample enters slot 0, oldest falls off the top
   assign window_next  = {window_reg[WW-DATA_WIDTH-1:0], fifo_data_i};

   always_comb begin
      pop = 1'b0;
      case (state_reg)
         FILL:    pop = !fifo_empty_i;
         WAIT:    pop = !fifo_empty_i;
         EMIT:    pop = handshake & !last_reg & !fifo_empty_i;
         default: pop = 1'b0;
      endcase
   end

   assign fifo_ren_o = pop & reset_i;
   assign window_o   = window_reg;
   assign valid_o    = valid_reg;
   assign last_o     = last_reg;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_reg    <= FILL;
         fill_cnt_reg <= '0;
         win_cnt_reg  <= '0;
         window_reg   <= '0;
         valid_reg    <= 1'b0;
         last_reg     <= 1'b0;
      end else begin
         case (state_reg)
            FILL: begin
               if (pop) begin
                  window_reg   <= window_next;
                  fill_cnt_reg <= fill_cnt_reg + 1'b1;
                  if (fill_cnt_reg == FCW'(KERNEL_SIZE - 1)) begin
                     state_reg <= EMIT;
                     valid_reg <= 1'b1;
                     last_reg  <= (LAST_WIN == 0);
                  end
               end
            end
            EMIT: begin
               if (handshake) begin
                  if (last_reg) begin
                     // frame complete: next frame refills from scratch
                     state_reg    <= FILL;
                     fill_cnt_reg <= '0;
                     win_cnt_reg  <= '0;
                     valid_reg    <= 1'b0;
                     last_reg     <= 1'b0;
                  end else if (pop) begin
                     window_reg  <= window_next;
                     win_cnt_reg <= win_cnt_next;
                     last_reg    <= (win_cnt_next == WCW'(LAST_WIN));
                  end else begin
                     state_reg <= WAIT;
                     valid_reg <= 1'b0;
                  end
               end
            end
            WAIT: begin
               if (pop) begin
                  window_reg  <= window_next;
                  win_cnt_reg <= win_cnt_next;
                  last_reg    <= (win_cnt_next == WCW'(LAST_WIN));
                  valid_reg   <= 1'b1;
                  state_reg   <= EMIT;
               end
            end
            default: state_reg <= FILL;
         endcase
      end
   end

`ifdef CONV_WINDOW_LOADER_STALL_CNT_EN
   logic [15:0] stall_cnt_reg;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         stall_cnt_reg <= '0;
      end else if (valid_reg && !ready_i && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_conv_window_loader.sv
// Directed bench for conv_window_loader (K=3, FRAME_LEN=5) with a simple FWFT FIFO model.
module tb_conv_window_loader;

   localparam int W = 16;
   localparam int K = 3;
   localparam int F = 5;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic [W-1:0]     fifo_data_i;
   logic             fifo_empty_i;
   logic             fifo_ren_o;
   logic [K*W-1:0]   window_o;
   logic             valid_o;
   logic             ready_i;
   logic             last_o;
`ifdef CONV_WINDOW_LOADER_STALL_CNT_EN
   logic [15:0]      stall_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] fmem [0:63];
   logic [6:0]   wr_ptr = '0;
   logic [6:0]   rd_ptr = '0;
   logic [6:0]   base;

   conv_window_loader #(.DATA_WIDTH(W), .KERNEL_SIZE(K), .FRAME_LEN(F)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_ren_o   (fifo_ren_o),
      .window_o     (window_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .last_o       (last_o)
`ifdef CONV_WINDOW_LOADER_STALL_CNT_EN
      ,
      .stall_cnt_o  (stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   assign fifo_empty_i = (rd_ptr == wr_ptr);
   assign fifo_data_i  = fmem[rd_ptr[5:0]];

   always @(posedge clk_i) begin
      if (fifo_ren_o) rd_ptr <= rd_ptr + 7'd1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic push(input logic [W-1:0] v);
      fmem[wr_ptr[5:0]] = v;
      wr_ptr = wr_ptr + 7'd1;
   endtask

   task automatic cyc();
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      cyc();
      reset_i = 1'b0;
      cyc();
      reset_i = 1'b1;
      base = rd_ptr;
   endtask

   // window literal listed newest first, packed oldest in the MSBs
   function automatic logic [63:0] w3(input logic [W-1:0] n, input logic [W-1:0] m, input logic [W-1:0] o);
      return 64'({o, m, n});
   endfunction

   logic        fr_valid [1:12];
   logic [63:0] fr_win   [1:12];
   logic        fr_last  [1:12];
   int          nwin;

   initial begin
      reset_i = 1'b0;
      ready_i = 1'b0;
      base    = '0;
      repeat (2) cyc();
      check("rst_valid",  64'(valid_o),    64'd0);
      check("rst_last",   64'(last_o),     64'd0);
      check("rst_window", 64'(window_o),   64'd0);
      check("rst_ren",    64'(fifo_ren_o), 64'd0);

      // basic frame
      reset_i = 1'b1;
      ready_i = 1'b1;
      base = rd_ptr;
      for (int i = 1; i <= 5; i++) push(W'(i));
      cyc(); check("basic_c1_valid", 64'(valid_o), 64'd0);
      cyc(); check("basic_c2_valid", 64'(valid_o), 64'd0);
      cyc(); check("basic_w1_valid", 64'(valid_o), 64'd1);
             check("basic_w1", 64'(window_o), w3(3, 2, 1));
             check("basic_w1_last", 64'(last_o), 64'd0);
      cyc(); check("basic_w2", 64'(window_o), w3(4, 3, 2));
             check("basic_w2_last", 64'(last_o), 64'd0);
      cyc(); check("basic_w3", 64'(window_o), w3(5, 4, 3));
             check("basic_w3_last", 64'(last_o), 64'd1);
             check("basic_w3_valid", 64'(valid_o), 64'd1);
      cyc(); check("basic_end_valid", 64'(valid_o), 64'd0);
             check("basic_pops", 64'(rd_ptr - base), 64'd5);
      // loader is back in FILL: three fresh pops form a new window
      push(7); push(8); push(9);
      cyc(); check("refill_c1_valid", 64'(valid_o), 64'd0);
      cyc(); check("refill_c2_valid", 64'(valid_o), 64'd0);
      cyc(); check("refill_valid", 64'(valid_o), 64'd1);
             check("refill_win", 64'(window_o), w3(9, 8, 7));

      // backpressure
      do_reset();
      ready_i = 1'b1;
      for (int i = 1; i <= 5; i++) push(W'(i));
      repeat (3) cyc();
      check("bp_w1", 64'(window_o), w3(3, 2, 1));
      cyc();
      check("bp_w2", 64'(window_o), w3(4, 3, 2));
      ready_i = 1'b0;
      #1 check("bp_ren_stall", 64'(fifo_ren_o), 64'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("bp_hold_valid", 64'(valid_o),    64'd1);
         check("bp_hold_win",   64'(window_o),   w3(4, 3, 2));
         check("bp_hold_ren",   64'(fifo_ren_o), 64'd0);
      end
      check("bp_pops", 64'(rd_ptr - base), 64'd4);
      ready_i = 1'b1;
      cyc();
      check("bp_w3", 64'(window_o), w3(5, 4, 3));
      check("bp_w3_last", 64'(last_o), 64'd1);

      // underflow
      do_reset();
      ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) push(W'(i));
      repeat (4) cyc();
      check("uf_w2", 64'(window_o), w3(4, 3, 2));
      check("uf_w2_ren", 64'(fifo_ren_o), 64'd0);
      cyc();
      check("uf_gap_valid", 64'(valid_o), 64'd0);
      check("uf_gap_ren", 64'(fifo_ren_o), 64'd0);
      cyc();
      check("uf_gap2_valid", 64'(valid_o), 64'd0);
      cyc();
      push(5);
      #1 check("uf_ren_resume", 64'(fifo_ren_o), 64'd1);
      cyc();
      check("uf_w3_valid", 64'(valid_o), 64'd1);
      check("uf_w3", 64'(window_o), w3(5, 4, 3));
      check("uf_w3_last", 64'(last_o), 64'd1);
      cyc();
      check("uf_pops", 64'(rd_ptr - base), 64'd5);

      // frame boundary
      do_reset();
      ready_i = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         fr_valid[i] = 1'b0; fr_win[i] = '0; fr_last[i] = 1'b0;
      end
      fr_valid[3]  = 1'b1; fr_win[3]  = w3(3, 2, 1);
      fr_valid[4]  = 1'b1; fr_win[4]  = w3(4, 3, 2);
      fr_valid[5]  = 1'b1; fr_win[5]  = w3(5, 4, 3);  fr_last[5]  = 1'b1;
      fr_valid[9]  = 1'b1; fr_win[9]  = w3(8, 7, 6);
      fr_valid[10] = 1'b1; fr_win[10] = w3(9, 8, 7);
      fr_valid[11] = 1'b1; fr_win[11] = w3(10, 9, 8); fr_last[11] = 1'b1;
      for (int i = 1; i <= 10; i++) push(W'(i));
      nwin = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         check($sformatf("fb_c%0d_valid", i), 64'(valid_o), 64'(fr_valid[i]));
         if (fr_valid[i]) begin
            check($sformatf("fb_c%0d_win", i),  64'(window_o), fr_win[i]);
            check($sformatf("fb_c%0d_last", i), 64'(last_o),   64'(fr_last[i]));
         end
         if (valid_o && ready_i) nwin++;
      end
      check("fb_windows", 64'(nwin), 64'd6);
      check("fb_pops", 64'(rd_ptr - base), 64'd10);

      // mid-fill reset
      do_reset();
      ready_i = 1'b1;
      push(1); push(2);
      cyc(); cyc();
      check("mr_pops", 64'(rd_ptr - base), 64'd2);
      reset_i = 1'b0;
      #1;
      check("mr_valid", 64'(valid_o), 64'd0);
      check("mr_window", 64'(window_o), 64'd0);
      push(7); push(8); push(9);
      #1 check("mr_ren_forced", 64'(fifo_ren_o), 64'd0);
      cyc();
      reset_i = 1'b1;
      cyc(); check("mr_c1_valid", 64'(valid_o), 64'd0);
      cyc(); check("mr_c2_valid", 64'(valid_o), 64'd0);
      cyc(); check("mr_w_valid", 64'(valid_o), 64'd1);
             check("mr_win", 64'(window_o), w3(9, 8, 7));

`ifdef CONV_WINDOW_LOADER_STALL_CNT_EN
      do_reset();
      check("sc_reset", 64'(stall_cnt_o), 64'd0);
      ready_i = 1'b1;
      push(1); push(2); push(3);
      repeat (3) cyc();
      check("sc_valid", 64'(valid_o), 64'd1);
      ready_i = 1'b0;
      repeat (5) cyc();
      check("sc_five", 64'(stall_cnt_o), 64'd5);
      repeat (70000) cyc();
      check("sc_sat", 64'(stall_cnt_o), 64'hFFFF);
      ready_i = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_window_loader.md
Name: conv_window_loader

Overview:
- Downstream consumer of the 16-bit double_fifo sample buffer.
- Pops samples from the FIFO and assembles a sliding window of KERNEL_SIZE samples for the 1-D convolution datapath.
- Presents each window to the conv layer over a valid/ready handshake.
- Frames of FRAME_LEN samples are windowed independently; no window ever spans two frames.

Parameters:
- DATA_WIDTH, 16: sample width; matches the FIFO data width.
- KERNEL_SIZE, 3: samples per window; must be >= 2.
- FRAME_LEN, 8: samples per frame; must be >= KERNEL_SIZE. Windows per frame = FRAME_LEN-KERNEL_SIZE+1.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- reset_i  in  1  asynchronous, active-low reset; 0 = reset asserted.
- fifo_data_i  in  DATA_WIDTH  FIFO head word; first-word-fall-through, valid whenever fifo_empty_i=0.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_ren_o  out  1  pop request; FIFO advances on the clock edge where this is 1.
- window_o  out  KERNEL_SIZE*DATA_WIDTH  window; slot 0 (LSBs) = newest sample, slot K-1 = oldest.
- valid_o  out  1  window_o is valid.
- ready_i  in  1  downstream accepts the window; handshake = valid_o & ready_i.
- last_o  out  1  qualifies the final window of a frame; meaningful only with valid_o.

Behaviour:
- Reset (async, while reset_i=0):
  - valid_o=0, last_o=0, window_o=0, fill_cnt=0, win_cnt=0, state=FILL.
  - fifo_ren_o is forced to 0 while reset is asserted.
  - Reset mid-frame discards the partial window and frame position.
- States: FILL, EMIT, WAIT. fill_cnt counts 0..K; win_cnt counts 0..FRAME_LEN-K.
- Shift operation: window <= {window[K-2:0], fifo_data_i}, i.e. new sample enters slot 0 and the oldest drops out.
- FILL:
  - valid_o=0; fifo_ren_o = !fifo_empty_i.
  - Each pop shifts the window and increments fill_cnt.
  - On the edge of the K-th pop: go to EMIT, valid_o=1 next cycle.
  - First-window latency = 1 cycle after the K-th pop edge.
- EMIT:
  - valid_o=1; window_o, last_o held stable until handshake.
  - last_o = (win_cnt == FRAME_LEN-K).
  - Handshake, not last, FIFO non-empty: fifo_ren_o=1, shift, win_cnt++, stay in EMIT. Gives one window per cycle at full throughput.
  - Handshake, not last, FIFO empty: fifo_ren_o=0, valid_o=0, go to WAIT.
  - Handshake on last: no pop that cycle, go to FILL; fill_cnt=0, win_cnt=0, valid_o=0, last_o=0. window_o contents are retained but invalid.
  - No handshake (ready_i=0): no pop, no state change; stall is unbounded.
- WAIT:
  - valid_o=0; fifo_ren_o = !fifo_empty_i.
  - On pop: shift, win_cnt++, go to EMIT.
- fifo_ren_o is combinational from state, fifo_empty_i and ready_i. It is never asserted when fifo_empty_i=1.
- Downstream is never presented with a window containing samples from two frames.
- Exactly FRAME_LEN pops per frame.

Optional Feature:
- Macro: CONV_WINDOW_LOADER_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, 16 bits.
  - Increments every cycle with valid_o=1 and ready_i=0.
  - Saturates at 16'hFFFF; async reset to 0; never cleared otherwise.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Use K=3, FRAME_LEN=5, W=16 for all scenarios.
- Basic frame: FIFO supplies 1,2,3,4,5 back-to-back, ready_i=1 -> valid_o rises 1 cycle after the 3rd pop. Windows {3,2,1}, {4,3,2}, {5,4,3} appear on consecutive cycles; last_o=1 only on {5,4,3}; exactly 5 pops; state returns to FILL.
- Backpressure: ready_i=0 for 4 cycles while {4,3,2} is presented -> window_o and valid_o stay stable; fifo_ren_o=0 throughout; {5,4,3} appears 1 cycle after ready_i returns to 1.
- Underflow: FIFO goes empty after sample 4 -> after the {4,3,2} handshake, valid_o=0 and fifo_ren_o=0. Sample 5 is written 3 cycles later -> popped, and {5,4,3} is valid on the next cycle.
- Frame boundary: samples 1..10 streamed -> frame 2 first window is {8,7,6}. {6,5,4} and {7,6,5} are never emitted; 6 windows total; last_o on {5,4,3} and {10,9,8}.
- Mid-fill reset: reset_i driven low after 2 pops -> valid_o=0 and window_o=0 immediately. After release, 3 fresh pops (7,8,9) are needed to produce window {9,8,7}.
- Macro defined: hold ready_i=0 for 5 cycles with valid_o=1 -> stall_cnt_o=5. Force 70000 stall cycles -> stall_cnt_o=16'hFFFF.
